// File: rtl/crowd_pkg.sv
// rtl/crowd_pkg.sv - shared widths, defaults and FSM encoding for the presence filter
package crowd_pkg;
  localparam int unsigned CYCLES_PER_CM = 2900;
  localparam int RAW_W = 21;
  localparam int CM_W  = 10;
  localparam int CNT_W = 5;
  localparam logic [CM_W-1:0] CM_NO_ECHO = 10'd1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    EVAL = 2'd2
  } state_t;
endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - restoring shift-subtract divider, one quotient bit per clock
module serial_divider
  import crowd_pkg::*;
#(
  parameter int unsigned DIVISOR = 2900
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [RAW_W-1:0] dividend,
  output logic            busy,
  output logic            done,
  output logic [CM_W-1:0] quotient
);
  localparam logic [RAW_W:0]   DIV_EXT = DIVISOR[RAW_W:0];
  localparam logic [RAW_W-1:0] SAT     = {{(RAW_W-CM_W){1'b0}}, CM_NO_ECHO};

  logic [RAW_W-1:0] dvd;
  logic [RAW_W:0]   rem;
  logic [RAW_W-1:0] quo;
  logic [CNT_W-1:0] cnt;
  logic [RAW_W:0]   trial;
  logic             ge;

  always_comb begin
    trial = {rem[RAW_W-1:0], dvd[RAW_W-1]};
    ge    = (trial >= DIV_EXT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd  <= '0;
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      dvd  <= dividend;
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      dvd <= {dvd[RAW_W-2:0], 1'b0};
      rem <= ge ? (trial - DIV_EXT) : trial;
      quo <= {quo[RAW_W-2:0], ge};
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(RAW_W-1)) busy <= 1'b0;
    end
  end

  // done marks the cycle whose edge retires the last quotient bit
  assign done     = busy && (cnt == CNT_W'(RAW_W-1));
  assign quotient = (quo > SAT) ? CM_NO_ECHO : quo[CM_W-1:0];
endmodule

// File: rtl/presence_filter.sv
// rtl/presence_filter.sv - converts echo counts to cm and debounces near/far into a presence level
module presence_filter #(
  parameter int unsigned CYCLES_PER_CM = crowd_pkg::CYCLES_PER_CM,
  parameter int unsigned NEAR_CM       = 50,
  parameter int unsigned FAR_CM        = 60,
  parameter int unsigned CONFIRM       = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [crowd_pkg::RAW_W-1:0]   distance_raw,
  input  logic                          new_measure,
  input  logic                          timeout,
  output logic [crowd_pkg::CM_W-1:0]    distance_cm,
  output logic                          cm_valid,
  output logic                          present,
  output logic                          arrive,
  output logic                          depart,
  output logic                          overrun
);
  localparam logic [crowd_pkg::CM_W-1:0] NEAR_T = NEAR_CM[crowd_pkg::CM_W-1:0];
  localparam logic [crowd_pkg::CM_W-1:0] FAR_T  = FAR_CM[crowd_pkg::CM_W-1:0];
  localparam logic [3:0]                 CONF_T = CONFIRM[3:0];

  crowd_pkg::state_t state, next_state;
  logic                       div_start, div_busy, div_done;
  logic [crowd_pkg::CM_W-1:0] div_q, sample_cm;
  logic                       to_sample;
  logic [3:0]                 streak, streak_inc;
  logic                       near, far, agree, oppose;

  serial_divider #(.DIVISOR(CYCLES_PER_CM)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (distance_raw),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= crowd_pkg::IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    div_start  = 1'b0;
    case (state)
      crowd_pkg::IDLE: begin
        if (timeout) begin
          next_state = crowd_pkg::EVAL;
        end else if (new_measure) begin
          next_state = crowd_pkg::DIV;
          div_start  = 1'b1;
        end
      end
      crowd_pkg::DIV: begin
        if (div_done)       next_state = crowd_pkg::EVAL;
        else if (!div_busy) next_state = crowd_pkg::IDLE;
      end
      crowd_pkg::EVAL: next_state = crowd_pkg::IDLE;
      default:         next_state = crowd_pkg::IDLE;
    endcase
  end

  // "agree" pushes toward the opposite presence level, "oppose" confirms the current one
  always_comb begin
    sample_cm  = to_sample ? crowd_pkg::CM_NO_ECHO : div_q;
    near       = (sample_cm < NEAR_T);
    far        = (sample_cm >= FAR_T);
    agree      = present ? far : near;
    oppose     = present ? near : far;
    streak_inc = (streak == 4'hF) ? 4'hF : streak + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      distance_cm <= crowd_pkg::CM_NO_ECHO;
      cm_valid    <= 1'b0;
      present     <= 1'b0;
      arrive      <= 1'b0;
      depart      <= 1'b0;
      overrun     <= 1'b0;
      streak      <= '0;
      to_sample   <= 1'b0;
    end else begin
      cm_valid <= 1'b0;
      arrive   <= 1'b0;
      depart   <= 1'b0;
      overrun  <= (state != crowd_pkg::IDLE) && (new_measure || timeout);
      if (state == crowd_pkg::IDLE) to_sample <= timeout;
      if (state == crowd_pkg::EVAL) begin
        distance_cm <= sample_cm;
        cm_valid    <= 1'b1;
        if (agree) begin
          if (streak_inc == CONF_T) begin
            present <= ~present;
            arrive  <= ~present;
            depart  <= present;
            streak  <= '0;
          end else begin
            streak <= streak_inc;
          end
        end else if (oppose) begin
          streak <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_presence_filter.sv
// tb/tb_presence_filter.sv - randomized and directed bench with a sample-level reference model
module tb_presence_filter;
  localparam int CPC  = 2900;
  localparam int NEAR = 50;
  localparam int FAR  = 60;
  localparam int CONF = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] distance_raw = '0;
  logic        new_measure = 1'b0;
  logic        timeout = 1'b0;
  logic [9:0]  distance_cm;
  logic        cm_valid, present, arrive, depart, overrun;

  always #5 clk = ~clk;

  presence_filter #(
    .CYCLES_PER_CM(CPC), .NEAR_CM(NEAR), .FAR_CM(FAR), .CONFIRM(CONF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .distance_raw(distance_raw),
    .new_measure(new_measure), .timeout(timeout),
    .distance_cm(distance_cm), .cm_valid(cm_valid), .present(present),
    .arrive(arrive), .depart(depart), .overrun(overrun)
  );

  wire [14:0] obs = {distance_cm, cm_valid, present, arrive, depart, overrun};
  localparam logic [14:0] RESET_OBS = {10'd1023, 5'b00000};

  int vectors = 0;
  int miscompares = 0;

  // Model: each accepted strobe yields one result at a fixed later edge; the unit is busy until then
  int   edge_n = 0;
  int   busy_end = -1;
  bit   inflight = 0;
  int   due_cm = 1023;
  bit   m_present = 0;
  int   m_streak = 0;
  logic [9:0] m_cm = 10'd1023;
  bit   e_cv, e_arr, e_dep, e_ovr;

  function logic [14:0] expected();
    return {m_cm, e_cv, m_present, e_arr, e_dep, e_ovr};
  endfunction

  task automatic model_reset();
    busy_end = -1; inflight = 0; m_present = 0; m_streak = 0; m_cm = 10'd1023;
    e_cv = 0; e_arr = 0; e_dep = 0; e_ovr = 0;
  endtask

  task automatic model_edge(input bit nm, input bit to, input int raw);
    bit is_near, is_far;
    e_cv = 0; e_arr = 0; e_dep = 0; e_ovr = 0;
    if (inflight && edge_n == busy_end) begin
      inflight = 0;
      e_cv = 1;
      m_cm = 10'(due_cm);
      is_near = (due_cm < NEAR);
      is_far  = (due_cm >= FAR);
      if (m_present ? is_far : is_near) begin
        m_streak++;
        if (m_streak >= CONF) begin
          m_streak = 0;
          if (m_present) e_dep = 1; else e_arr = 1;
          m_present = !m_present;
        end
      end else if (m_present ? is_near : is_far) begin
        m_streak = 0;
      end
    end
    if (nm || to) begin
      if (edge_n <= busy_end) e_ovr = 1;
      else begin
        inflight = 1;
        if (to) begin
          due_cm = 1023; busy_end = edge_n + 1;
        end else begin
          due_cm = raw / CPC;
          if (due_cm > 1023) due_cm = 1023;
          busy_end = edge_n + 22;
        end
      end
    end
    edge_n++;
  endtask

  // Drive one cycle's inputs at a falling edge and land on the next falling edge
  task automatic apply(input bit nm, input bit to, input int raw);
    new_measure = nm; timeout = to; distance_raw = 21'(raw);
    model_edge(nm, to, raw);
    @(negedge clk);
    new_measure = 0; timeout = 0;
  endtask

  task automatic run_sample(input bit to, input int raw, input int len,
                            output int dev, output int lat, output logic [14:0] cap);
    dev = 0; lat = -1; cap = '0;
    for (int i = 1; i <= len; i++) begin
      apply(i == 1 && !to, i == 1 && to, raw);
      if (obs !== expected()) dev++;
      if (cm_valid === 1'b1 && lat < 0) begin lat = i; cap = obs; end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    vectors++;
    if (obs !== RESET_OBS) begin miscompares++; $display("FAIL reset_state got %h want %h", obs, RESET_OBS); end
    new_measure = 1; timeout = 1; distance_raw = 21'd1000;
    @(negedge clk);
    new_measure = 0; timeout = 0;
    vectors++;
    if (obs !== RESET_OBS) begin miscompares++; $display("FAIL reset_hold got %h want %h", obs, RESET_OBS); end
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_divide();
    int dev, lat; logic [14:0] cap;
    run_sample(0, 142100, 24, dev, lat, cap);
    vectors++; if (dev != 0)  begin miscompares++; $display("FAIL divide_model got %0d bad cycles want 0", dev); end
    vectors++; if (lat != 23) begin miscompares++; $display("FAIL divide_latency got %0d want 23", lat); end
    vectors++; if (cap[14:5] !== 10'd49) begin miscompares++; $display("FAIL divide_cm got %0d want 49", cap[14:5]); end
  endtask

  task automatic test_inband_confirm();
    int dev, lat; logic [14:0] cap;
    run_sample(1, 0, 3, dev, lat, cap);
    vectors++; if (dev != 0 || lat != 2) begin miscompares++; $display("FAIL clear_timeout got dev %0d lat %0d want 0 2", dev, lat); end
    for (int k = 0; k < 3; k++) begin
      run_sample(0, 145000, 24, dev, lat, cap);
      vectors++;
      if (dev != 0 || cap[14:5] !== 10'd50 || cap[3:1] !== 3'b000) begin
        miscompares++; $display("FAIL inband_%0d got dev %0d cm %0d flags %b want 0 50 000", k, dev, cap[14:5], cap[3:1]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      run_sample(0, 142100, 24, dev, lat, cap);
      vectors++;
      if (dev != 0 || cap[3] !== (k == 2) || cap[2] !== (k == 2)) begin
        miscompares++; $display("FAIL confirm_%0d got dev %0d present %b arrive %b want 0 %0d %0d", k, dev, cap[3], cap[2], k == 2, k == 2);
      end
    end
  endtask

  task automatic test_departure();
    int dev, lat; logic [14:0] cap;
    for (int k = 0; k < 2; k++) begin
      run_sample(1, 0, 3, dev, lat, cap);
      vectors++;
      if (dev != 0 || cap[3] !== 1'b1 || cap[1] !== 1'b0) begin
        miscompares++; $display("FAIL depart_pre_%0d got dev %0d present %b depart %b want 0 1 0", k, dev, cap[3], cap[1]);
      end
    end
    run_sample(0, 29000, 24, dev, lat, cap);
    vectors++;
    if (dev != 0 || cap[14:5] !== 10'd10 || cap[3] !== 1'b1) begin
      miscompares++; $display("FAIL depart_near got dev %0d cm %0d present %b want 0 10 1", dev, cap[14:5], cap[3]);
    end
    for (int k = 0; k < 3; k++) begin
      run_sample(1, 0, 3, dev, lat, cap);
      vectors++;
      if (dev != 0 || cap[14:5] !== 10'd1023 || cap[1] !== (k == 2) || cap[3] !== (k != 2)) begin
        miscompares++; $display("FAIL depart_to_%0d got dev %0d cm %0d depart %b present %b", k, dev, cap[14:5], cap[1], cap[3]);
      end
    end
  endtask

  task automatic test_overrun();
    int ovr_at, cv_at; logic [9:0] cm_seen;
    cv_at = -1; cm_seen = '0;
    for (int i = 1; i <= 3; i++) begin
      apply(i == 1, i == 1, 142100);
      vectors++;
      if (obs !== expected()) begin miscompares++; $display("FAIL simul_cyc%0d got %h want %h", i, obs, expected()); end
      if (cm_valid === 1'b1 && cv_at < 0) begin cv_at = i; cm_seen = distance_cm; end
    end
    vectors++;
    if (cv_at != 2 || cm_seen !== 10'd1023) begin miscompares++; $display("FAIL simul_timeout_wins got lat %0d cm %0d want 2 1023", cv_at, cm_seen); end
    ovr_at = -1; cv_at = -1;
    for (int i = 1; i <= 26; i++) begin
      apply(i == 1 || i == 6, 0, (i == 6) ? 29000 : 142100);
      vectors++;
      if (obs !== expected()) begin miscompares++; $display("FAIL overrun_cyc%0d got %h want %h", i, obs, expected()); end
      if (overrun === 1'b1) ovr_at = (ovr_at < 0) ? i : 99;
      if (cm_valid === 1'b1 && cv_at < 0) begin cv_at = i; cm_seen = distance_cm; end
    end
    vectors++;
    if (ovr_at != 6) begin miscompares++; $display("FAIL overrun_pulse got cycle %0d want 6", ovr_at); end
    vectors++;
    if (cv_at != 23 || cm_seen !== 10'd49) begin miscompares++; $display("FAIL overrun_result got lat %0d cm %0d want 23 49", cv_at, cm_seen); end
  endtask

  task automatic test_random();
    int sel, raw;
    bit nm, to;
    for (int i = 0; i < 700; i++) begin
      nm = ($urandom_range(0, 9) == 0);
      to = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0, 1:    raw = $urandom_range(0, NEAR * CPC - 1);
        2:       raw = $urandom_range(NEAR * CPC, FAR * CPC - 1);
        default: raw = $urandom_range(FAR * CPC, (1 << 21) - 1);
      endcase
      apply(nm, to, raw);
      vectors++;
      if (obs !== expected()) begin miscompares++; $display("FAIL random_cyc%0d got %h want %h", i, obs, expected()); end
    end
  endtask

  task automatic test_reset_mid_divide();
    int dev, lat; logic [14:0] cap;
    bit saw_cv;
    for (int k = 0; k < 3; k++) run_sample(0, 20000, 24, dev, lat, cap);
    vectors++;
    if (present !== 1'b1) begin miscompares++; $display("FAIL pre_reset_present got %b want 1", present); end
    apply(1, 0, 142100);
    for (int i = 0; i < 9; i++) apply(0, 0, 0);
    #2 rst_n = 0;
    #1;
    vectors++;
    if (obs !== RESET_OBS) begin miscompares++; $display("FAIL reset_async got %h want %h", obs, RESET_OBS); end
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    saw_cv = 0;
    for (int i = 0; i < 30; i++) begin
      apply(0, 0, 0);
      if (cm_valid === 1'b1) saw_cv = 1;
    end
    vectors++;
    if (saw_cv || obs !== RESET_OBS) begin miscompares++; $display("FAIL reset_abort got cv %b obs %h want 0 %h", saw_cv, obs, RESET_OBS); end
    run_sample(0, 174000, 24, dev, lat, cap);
    vectors++;
    if (dev != 0 || lat != 23 || cap[14:5] !== 10'd60) begin
      miscompares++; $display("FAIL post_reset got dev %0d lat %0d cm %0d want 0 23 60", dev, lat, cap[14:5]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_divide();
    test_inband_confirm();
    test_departure();
    test_overrun();
    test_random();
    test_reset_mid_divide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/presence_filter.md
PRESENCE_FILTER -- requirements
Module: presence_filter

Interface
REQ-001 SHALL provide parameter CYCLES_PER_CM, default 2900, the raw echo clock counts per centimetre at 50 MHz.
REQ-002 SHALL provide parameter NEAR_CM, default 50, the near threshold: cm < NEAR_CM is a near sample.
REQ-003 SHALL provide parameter FAR_CM, default 60, the far threshold: cm >= FAR_CM is a far sample; FAR_CM > NEAR_CM.
REQ-004 SHALL provide parameter CONFIRM, default 3, the number of consecutive agreeing samples (range 1..15) needed to change state.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  system clock, 50 MHz.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 distance_raw  in  21  echo-high count from the ultrasonic stage.
REQ-008 new_measure  in  1  one-cycle strobe marking distance_raw as valid.
REQ-009 timeout  in  1  one-cycle strobe marking a missing echo.
REQ-010 distance_cm  out  10  latest distance in cm; 1023 means no echo.
REQ-011 cm_valid  out  1  one-cycle strobe marking distance_cm as updated.
REQ-012 present  out  1  filtered presence level.
REQ-013 arrive  out  1  one-cycle pulse on a present 0->1 transition.
REQ-014 depart  out  1  one-cycle pulse on a present 1->0 transition.
REQ-015 overrun  out  1  one-cycle pulse when a strobe is dropped while busy.

Function
REQ-016 FSM SHALL have the states IDLE, DIV, and EVAL.
REQ-017 In IDLE, timeout SHALL take priority over new_measure: go to EVAL with quotient 1023 and no division.
REQ-018 In IDLE, new_measure alone SHALL latch distance_raw and go to DIV.
REQ-019 DIV SHALL run a restoring shift-subtract divide by CYCLES_PER_CM, one quotient bit per cycle, for exactly 21 cycles, then go to EVAL.
REQ-020 A quotient above 1023 SHALL saturate to 1023.
REQ-021 EVAL (1 cycle) SHALL register distance_cm, assert cm_valid, classify the sample, update the streak counter, and return to IDLE.
REQ-022 Divide-path latency SHALL be fixed: cm_valid high 23 clocks after the edge that sampled new_measure.
REQ-023 Timeout-path latency SHALL be 2 clocks.
REQ-024 Any new_measure or timeout arriving in DIV or EVAL SHALL be dropped, pulse overrun for 1 cycle, and leave the in-flight result unchanged.
REQ-025 While present=0: a near sample SHALL increment streak; a far sample SHALL clear it; an in-band sample (NEAR_CM <= cm < FAR_CM) SHALL leave it unchanged.
REQ-026 While present=0, when streak reaches CONFIRM, present SHALL be set, arrive pulsed, and streak cleared, all in the cycle cm_valid is high.
REQ-027 While present=1, the rules SHALL mirror REQ-025/026 with far and near swapped, and depart pulsed instead of arrive.
REQ-028 A timeout sample (1023) SHALL be classed as far.
REQ-029 streak SHALL be 4 bits and saturate; arrive and depart SHALL never be high together.
REQ-030 cm_valid, arrive, depart, and overrun SHALL each be high for at most one cycle per event.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, distance_cm 1023, streak 0, and cm_valid, present, arrive, depart, overrun all 0.
REQ-032 Reset asserted mid-DIV SHALL abort the divide with no cm_valid produced.
REQ-033 The first strobe after reset release SHALL be processed normally.

Structure
REQ-034 A shared package crowd_pkg SHALL hold CYCLES_PER_CM, the raw/cm widths (21/10), CM_NO_ECHO=1023, and the FSM state encodings.
REQ-035 The divider SHALL be a sub-module serial_divider (start, busy, done, 21-bit dividend, 10-bit saturated quotient), instantiated once.

Verification
REQ-036 Divide path: distance_raw=142100 with new_measure -> 23 clocks later cm_valid=1, distance_cm=49 (near sample).
REQ-037 In-band then confirm: raw=145000 (50 cm) ×3 -> present stays 0, streak 0; then 142100 ×3 -> arrive pulses with the third cm_valid, present=1.
REQ-038 Departure: while present, 2 timeouts, 1 near (cm 10), then 3 timeouts -> streak cleared by the near sample, depart pulses on the final timeout's EVAL cycle, distance_cm=1023.
REQ-039 Simultaneous and overrun: new_measure and timeout together -> timeout wins; new_measure 5 clocks into DIV -> overrun=1 for 1 cycle, first result still output.
REQ-040 Reset mid-divide: rst_n low at DIV cycle 10 -> all outputs 0 / 1023 immediately, no cm_valid; the next strobe yields the correct result.
